// File: rtl/quotient_multiplier.sv
// Sequential shift-add multiplier: product = quotient * divisor (+ remainder), quotient bits MSB-first.
// Latency: done/product valid the cycle after the 16th RUN edge (dividendBITS+1 edges incl. accept); 18-cycle issue interval.
// Backpressure: start is honoured only while in_ready=1; start and operand changes while busy are ignored.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start/in_ready        request and accept handshake (accept on an edge with start=1 in IDLE)
//   divisor, quotient     operands latched on accept
//   remainder             addend latched on accept; present only when REMAINDER_ADD_EN is defined
//   busy, done            busy in RUN and DONE; done is a one-cycle completion pulse
//   product               result register, held until the next completion or reset
// Optional build macro: REMAINDER_ADD_EN (adds the remainder port and the final addition).
module quotient_multiplier #(
    parameter int divisorBITS  = 8,
    parameter int dividendBITS = 16,
    localparam int prodBITS    = divisorBITS + dividendBITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [divisorBITS-1:0]  divisor,
    input  logic [dividendBITS-1:0] quotient,
`ifdef REMAINDER_ADD_EN
    input  logic [divisorBITS-1:0]  remainder,
`endif
    output logic                    in_ready,
    output logic                    busy,
    output logic                    done,
    output logic [prodBITS-1:0]     product
);

    localparam int CNT_W = $clog2(dividendBITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(dividendBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [prodBITS-1:0]     acc_q, acc_d;
    logic [dividendBITS-1:0] qreg_q, qreg_d;
    logic [divisorBITS-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [prodBITS-1:0]     product_q, product_d;
    logic                    done_q, done_d;
    logic [prodBITS-1:0]     acc_step;
    logic [prodBITS-1:0]     final_sum;
`ifdef REMAINDER_ADD_EN
    logic [divisorBITS-1:0]  rem_q, rem_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            qreg_q    <= '0;
            dvs_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
`ifdef REMAINDER_ADD_EN
            rem_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            qreg_q    <= qreg_d;
            dvs_q     <= dvs_d;
            count_q   <= count_d;
            product_q <= product_d;
            done_q    <= done_d;
`ifdef REMAINDER_ADD_EN
            rem_q     <= rem_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        qreg_d    = qreg_q;
        dvs_d     = dvs_q;
        count_d   = count_q;
        product_d = product_q;
        done_d    = 1'b0;
`ifdef REMAINDER_ADD_EN
        rem_d     = rem_q;
`endif
        // One Horner step: double the partial product, add the divisor when the
        // current (most significant remaining) quotient bit is set.
        acc_step = {acc_q[prodBITS-2:0], 1'b0}
                 + (qreg_q[dividendBITS-1] ? {{dividendBITS{1'b0}}, dvs_q} : '0);
`ifdef REMAINDER_ADD_EN
        final_sum = acc_step + {{dividendBITS{1'b0}}, rem_q};
`else
        final_sum = acc_step;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d   = divisor;
                    qreg_d  = quotient;
`ifdef REMAINDER_ADD_EN
                    rem_d   = remainder;
`endif
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_step;
                qreg_d  = {qreg_q[dividendBITS-2:0], 1'b0};
                count_d = count_q + 1'b1;
                if (count_q == LAST_CNT) begin
                    // Result (and optional addend) lands in the same edge as the last step.
                    product_d = final_sum;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign product  = product_q;

endmodule

// File: tb/tb_quotient_multiplier.sv
module tb_quotient_multiplier;

`ifdef REMAINDER_ADD_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [23:0] product;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_product = 0;

    always #5 clk = ~clk;

    quotient_multiplier dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .divisor  (divisor),
        .quotient (quotient),
`ifdef REMAINDER_ADD_EN
        .remainder(remainder),
`endif
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    typedef struct {
        logic [15:0] q;
        logic [7:0]  d;
        logic [7:0]  r;
        logic [31:0] exp_nf;
        logic [31:0] exp_f;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the product is just quotient*divisor, plus the addend when enabled.
    function automatic logic [31:0] model(input logic [15:0] q, input logic [7:0] d, input logic [7:0] r);
        return int'(q) * int'(d) + (FEAT ? int'(r) : 0);
    endfunction

    // Issue one operation, scramble inputs while busy, check latency, pulse width and result.
    task automatic do_op(input logic [15:0] q, input logic [7:0] d, input logic [7:0] r,
                         input logic [31:0] exp, input string nm);
        int  k;
        bit  stable;
        bit  busy_ok;
        @(negedge clk);
        chk({nm, " in_ready before"}, {31'b0, in_ready}, 1);
        quotient = q; divisor = d; remainder = r; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0; stable = 1'b1; busy_ok = 1'b1;
        while (!done && k < 30) begin
            if (product !== last_product[23:0]) stable = 1'b0;
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
            quotient = 16'($urandom); divisor = 8'($urandom); remainder = 8'($urandom);
            start = $urandom_range(0, 1) == 1;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({nm, " latency"}, k, 16);
        chk({nm, " product"}, {8'b0, product}, exp);
        chk({nm, " product stable"}, {31'b0, stable}, 1);
        chk({nm, " busy during run"}, {31'b0, busy_ok}, 1);
        @(negedge clk);
        chk({nm, " done width"}, {31'b0, done}, 0);
        chk({nm, " in_ready after"}, {31'b0, in_ready}, 1);
        last_product = {8'b0, product};
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   dones;
        int   done_ct;
        int   last_acc;
        logic prev_done;
        logic [31:0] expq[$];
        logic [31:0] e;

        vecs[0] = '{16'd13,    8'd200,  8'd7,   32'd2600,     32'd2607,     "basic"};
        vecs[1] = '{16'hFFFF,  8'hFF,   8'hFE,  32'hFEFF01,   32'hFEFFFF,   "max"};
        vecs[2] = '{16'h1234,  8'h00,   8'h00,  32'd0,        32'd0,        "div zero"};
        vecs[3] = '{16'h0000,  8'h55,   8'h00,  32'd0,        32'd0,        "quo zero"};
        vecs[4] = '{16'h0000,  8'h00,   8'd9,   32'd0,        32'd9,        "zero rem"};
        vecs[5] = '{16'h8000,  8'h80,   8'h00,  32'h400000,   32'h400000,   "msb only"};
        vecs[6] = '{16'h0001,  8'h01,   8'h01,  32'd1,        32'd2,        "ones"};

        rst = 1'b1; start = 1'b0; quotient = '0; divisor = '0; remainder = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", {31'b0, in_ready}, 1);
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset done", {31'b0, done}, 0);
        chk("reset product", {8'b0, product}, 0);

        for (int i = 0; i < 7; i++)
            do_op(vecs[i].q, vecs[i].d, vecs[i].r, FEAT ? vecs[i].exp_f : vecs[i].exp_nf, vecs[i].name);

        // start held high with fresh operands every cycle
        expq.delete(); dones = 0; last_acc = -1; prev_done = 1'b0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (prev_done) chk("stream done width", 1, 0);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("stream product", {8'b0, product}, e);
                end else chk("stream spurious done", 1, 0);
                dones++;
            end
            prev_done = done;
            quotient = 16'($urandom); divisor = 8'($urandom); remainder = 8'($urandom);
            start = (cyc < 60);
            if (in_ready && start) begin
                expq.push_back(model(quotient, divisor, remainder));
                if (last_acc >= 0) chk("stream accept interval", cyc - last_acc, 18);
                last_acc = cyc;
            end else if (!in_ready) begin
                if (busy !== 1'b1) chk("stream busy", {31'b0, busy}, 1);
            end
        end
        start = 1'b0;
        chk("stream done count", dones, 4);
        last_product = {8'b0, product};

        // reset in the middle of RUN
        @(negedge clk);
        quotient = 16'hABCD; divisor = 8'h77; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre-reset busy", {31'b0, busy}, 1);
        rst = 1'b1;
        #1;
        chk("midrun reset product", {8'b0, product}, 0);
        chk("midrun reset in_ready", {31'b0, in_ready}, 1);
        chk("midrun reset done", {31'b0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        done_ct = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) done_ct++;
        end
        chk("midrun no done pulse", done_ct, 0);
        chk("post-reset product", {8'b0, product}, 0);
        last_product = 0;
        do_op(16'd3, 8'd5, 8'd0, 32'd15, "after reset");

        // randomized against the reference model
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] rq;
            logic [7:0]  rd;
            logic [7:0]  rr;
            rq = 16'($urandom); rd = 8'($urandom); rr = 8'($urandom);
            do_op(rq, rd, rr, model(rq, rd, rr), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quotient_multiplier.md
Name: quotient_multiplier

Overview:
- Sequential shift-add multiplier; the inverse of the restoring divider chain.
- Takes a quotient (dividendBITS) and a divisor (divisorBITS) and rebuilds the dividend as product = quotient * divisor (+ remainder, optional).
- Consumes quotient bits MSB-first, one bit per clock, mirroring the order in which the divider stages produce them.
- Used as a datapath block and as a self-check engine beside the divider.

Parameters:
- divisorBITS, 8, divisor and remainder width.
- dividendBITS, 16, quotient width; equals the iteration count.
- prodBITS, divisorBITS+dividendBITS, product width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while in_ready=1.
- divisor  input  divisorBITS  multiplicand, latched on accept.
- quotient  input  dividendBITS  multiplier, latched on accept.
- remainder  input  divisorBITS  addend, latched on accept; present only with REMAINDER_ADD_EN.
- in_ready  output  1  high in IDLE only.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- product  output  prodBITS  result register; holds its value until the next completion.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; acc, count, product, done, busy, latched operands all 0; in_ready=1 once reset is released.
  - An operation interrupted by reset is discarded; it produces no done pulse and leaves no partial product.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); busy = (state!=IDLE).
- IDLE:
  - On an edge with start=1: latch divisor, quotient (and remainder); acc=0; count=0; go to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - acc = (acc<<1) + (qreg[MSB] ? zero-extended divisor : 0); qreg = qreg<<1; count = count+1.
  - All arithmetic is unsigned and prodBITS wide. No overflow is possible: max (2^16-1)*255+255 < 2^24.
- Final RUN edge (count==dividendBITS-1):
  - product = final acc (+ remainder if enabled); done=1; go to DONE.
- DONE:
  - done=1 for exactly this one cycle; next edge: done=0, go to IDLE.
- Latency: start accepted at edge E0; product valid and done=1 in the cycle after edge E16 (dividendBITS+1 edges including accept); in_ready=1 again after edge E17. Minimum issue interval is 18 cycles.
- start while busy (RUN or DONE) is ignored; operand changes while busy have no effect.
- divisor=0 or quotient=0 completes normally with the same latency; product=0 (plus remainder if enabled).
- product is never cleared except by reset.

Optional Feature:
- Macro: REMAINDER_ADD_EN.
- Defined:
  - remainder port exists and is latched on accept.
  - Final product = quotient*divisor + remainder, added in the same edge that writes product; no extra latency.
- Undefined:
  - remainder port and its register are absent.
  - product = quotient*divisor.
  - Timing is identical in both builds.

Test Plan:
- Basic: quotient=13, divisor=200 (remainder=7 with feature) -> done one cycle after edge E16; product=2600 (0x000A28), or 2607 (0x000A2F) with feature.
- Max operands: quotient=0xFFFF, divisor=0xFF, remainder=0xFE -> product=0xFEFF01 without feature, 0xFEFFFF with feature; no wrap.
- Zero cases: divisor=0, quotient=0x1234 -> product=0 after the full 17-edge latency; quotient=0, divisor=0x55 -> product=0.
- start held high continuously with new operands each cycle:
  - operands present at accept edges only are used.
  - in_ready=0 during RUN and DONE.
  - Accepts 18 cycles apart; done pulses exactly one cycle wide.
- Reset at cycle 8 of RUN:
  - product=0, in_ready=1, no done pulse.
  - A subsequent op (quotient=3, divisor=5) -> product=15 with nominal latency.
- Random: 1000 random quotient/divisor(/remainder) pairs -> product equals reference quotient*divisor(+remainder); product stable between done pulses.
